exers_station: RTL and testbench

Execution reservation station: the receiving end of the rename/dispatch write interface for non-memory, non-CSR instructions. It accepts dispatched micro-ops with operands that are either values or ROB tags. It snoops the writeback bus to capture pending operands and issues the oldest fully-ready entry to the integer execution unit. It sits between rename and the ALU and back-pressures rename through `exers_stall`.

---
 rtl/exers_station.sv | 110 +++++++++++
 tb/tb_exers_station.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exers_station.sv
// exers_station: collapsing-age reservation station with writeback wakeup and a registered issue slot
module exers_station #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rename_exers_write,
  input  logic [4:0]  rename_op,
  input  logic [6:0]  rename_robid,
  input  logic [5:0]  rename_rd,
  input  logic        rename_op1ready,
  input  logic [31:0] rename_op1,
  input  logic        rename_op2ready,
  input  logic [31:0] rename_op2,
  input  logic [31:0] rename_imm,
  output logic        exers_stall,
  input  logic        wb_valid,
  input  logic [6:0]  wb_robid,
  input  logic [31:0] wb_result,
  input  logic        rob_flush,
  output logic        exers_issue_valid,
  output logic [4:0]  exers_issue_op,
  output logic [6:0]  exers_issue_robid,
  output logic [5:0]  exers_issue_rd,
  output logic [31:0] exers_issue_op1,
  output logic [31:0] exers_issue_op2,
  output logic [31:0] exers_issue_imm,
  input  logic        alu_stall
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH);
  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic        r1;
    logic [31:0] op1;
    logic        r2;
    logic [31:0] op2;
    logic [31:0] imm;
  } ent_t;
  ent_t [DEPTH-1:0] ent_q, ent_d;
  ent_t [DEPTH:0]   wk;
  ent_t             nw, iss_q, iss_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    sel;
  logic             found, can_issue, wr;
  assign exers_stall = (count_q == CW'(DEPTH));
  always_comb begin
    wk = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wk[i] = ent_q[i];
      if (wb_valid && !wk[i].r1 && wk[i].op1[6:0] == wb_robid) begin
        wk[i].op1 = wb_result;
        wk[i].r1  = 1'b1;
      end
      if (wb_valid && !wk[i].r2 && wk[i].op2[6:0] == wb_robid) begin
        wk[i].op2 = wb_result;
        wk[i].r2  = 1'b1;
      end
    end
    // incoming operands that match this cycle's writeback are captured directly
    nw = '{v: 1'b1, op: rename_op, robid: rename_robid, rd: rename_rd,
           r1: rename_op1ready, op1: rename_op1, r2: rename_op2ready, op2: rename_op2, imm: rename_imm};
    if (wb_valid && !nw.r1 && nw.op1[6:0] == wb_robid) begin
      nw.op1 = wb_result;
      nw.r1  = 1'b1;
    end
    if (wb_valid && !nw.r2 && nw.op2[6:0] == wb_robid) begin
      nw.op2 = wb_result;
      nw.r2  = 1'b1;
    end
    sel   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].v && ent_q[i].r1 && ent_q[i].r2) begin
        sel   = SW'(i);
        found = 1'b1;
      end
    end
    can_issue = found && (!iss_q.v || !alu_stall);
    wr        = rename_exers_write && !exers_stall && !rob_flush;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (can_issue && i >= int'(sel)) ? wk[i+1] : wk[i];
      if (wr && i == int'(count_q) - int'(can_issue)) ent_d[i] = nw;
    end
    if (rob_flush) ent_d = '0;
    count_d = rob_flush ? '0 : count_q - CW'(can_issue) + CW'(wr);
    iss_d   = rob_flush ? '0 : can_issue ? ent_q[sel] : alu_stall ? iss_q : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q   <= '0;
      count_q <= '0;
      iss_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      iss_q   <= iss_d;
    end
  end
  assign exers_issue_valid = iss_q.v;
  assign exers_issue_op    = iss_q.op;
  assign exers_issue_robid = iss_q.robid;
  assign exers_issue_rd    = iss_q.rd;
  assign exers_issue_op1   = iss_q.op1;
  assign exers_issue_op2   = iss_q.op2;
  assign exers_issue_imm   = iss_q.imm;
endmodule

// File: tb/tb_exers_station.sv
// tb_exers_station: directed vectors for exers_station with hand-computed expectations
module tb_exers_station;
  logic        clk = 1'b0;
  logic        rst;
  logic        rename_exers_write;
  logic [4:0]  rename_op;
  logic [6:0]  rename_robid;
  logic [5:0]  rename_rd;
  logic        rename_op1ready;
  logic [31:0] rename_op1;
  logic        rename_op2ready;
  logic [31:0] rename_op2;
  logic [31:0] rename_imm;
  logic        exers_stall;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic        rob_flush;
  logic        exers_issue_valid;
  logic [4:0]  exers_issue_op;
  logic [6:0]  exers_issue_robid;
  logic [5:0]  exers_issue_rd;
  logic [31:0] exers_issue_op1;
  logic [31:0] exers_issue_op2;
  logic [31:0] exers_issue_imm;
  logic        alu_stall;
  int errors = 0;
  int checks = 0;

  exers_station #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .rename_exers_write(rename_exers_write), .rename_op(rename_op), .rename_robid(rename_robid),
    .rename_rd(rename_rd), .rename_op1ready(rename_op1ready), .rename_op1(rename_op1),
    .rename_op2ready(rename_op2ready), .rename_op2(rename_op2), .rename_imm(rename_imm),
    .exers_stall(exers_stall), .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_result(wb_result),
    .rob_flush(rob_flush), .exers_issue_valid(exers_issue_valid), .exers_issue_op(exers_issue_op),
    .exers_issue_robid(exers_issue_robid), .exers_issue_rd(exers_issue_rd),
    .exers_issue_op1(exers_issue_op1), .exers_issue_op2(exers_issue_op2),
    .exers_issue_imm(exers_issue_imm), .alu_stall(alu_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rename_exers_write = 1'b0;
    wb_valid = 1'b0;
    rob_flush = 1'b0;
  endtask

  task automatic put(input logic [6:0] id, input logic a_r, input logic [31:0] a,
                     input logic b_r, input logic [31:0] b);
    rename_exers_write = 1'b1;
    rename_robid = id;
    rename_op = id[4:0];
    rename_rd = id[5:0];
    rename_op1ready = a_r;
    rename_op1 = a;
    rename_op2ready = b_r;
    rename_op2 = b;
    rename_imm = 32'h1000 + 32'(id);
  endtask

  task automatic wb(input logic [6:0] id, input logic [31:0] val);
    wb_valid = 1'b1;
    wb_robid = id;
    wb_result = val;
  endtask

  task automatic chk_iss(input string tag, input logic [6:0] id, input logic [31:0] a, input logic [31:0] b);
    chk({tag, ".valid"}, 32'(exers_issue_valid), 32'd1);
    chk({tag, ".robid"}, 32'(exers_issue_robid), 32'(id));
    chk({tag, ".op1"}, exers_issue_op1, a);
    chk({tag, ".op2"}, exers_issue_op2, b);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    put(7'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    rename_exers_write = 1'b0;
    wb_robid = '0;
    wb_result = '0;
    alu_stall = 1'b0;
    #12;
    chk("rst.valid", 32'(exers_issue_valid), 32'd0);
    chk("rst.stall", 32'(exers_stall), 32'd0);
    chk("rst.robid", 32'(exers_issue_robid), 32'd0);
    chk("rst.op1", exers_issue_op1, 32'd0);
    #5 rst = 1'b1;
    // basic issue with 1-cycle station latency
    put(7'd3, 1'b1, 32'd5, 1'b1, 32'd7);
    rename_op = 5'd2;
    tick(); idle();
    chk("basic.lat", 32'(exers_issue_valid), 32'd0);
    chk("basic.stall", 32'(exers_stall), 32'd0);
    tick();
    chk_iss("basic", 7'd3, 32'd5, 32'd7);
    chk("basic.op", 32'(exers_issue_op), 32'd2);
    chk("basic.imm", exers_issue_imm, 32'h1003);
    chk("basic.rd", 32'(exers_issue_rd), 32'd3);
    tick();
    chk("basic.drain", 32'(exers_issue_valid), 32'd0);
    // wakeup
    put(7'd4, 1'b0, 32'h12, 1'b1, 32'd9);
    tick(); idle();
    tick();
    chk("wake.wait", 32'(exers_issue_valid), 32'd0);
    wb(7'h12, 32'h100);
    tick(); idle();
    chk("wake.edge", 32'(exers_issue_valid), 32'd0);
    tick();
    chk_iss("wake", 7'd4, 32'h100, 32'd9);
    tick();
    // bypass of a writeback coincident with dispatch
    put(7'd5, 1'b0, 32'd20, 1'b1, 32'd1);
    wb(7'd20, 32'hAB);
    tick(); idle();
    tick();
    chk_iss("byp", 7'd5, 32'hAB, 32'd1);
    tick();
    // full / age ordering with ALU stalled
    alu_stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      put(7'(i), 1'b1, 32'(i * 10), 1'b1, 32'(i));
      tick();
      chk($sformatf("full.stall%0d", i), 32'(exers_stall), (i >= 5) ? 32'd1 : 32'd0);
    end
    idle();
    chk_iss("full.hold", 7'd1, 32'd10, 32'd1);
    alu_stall = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk_iss($sformatf("full.ord%0d", i), 7'(i), 32'(i * 10), 32'(i));
      chk($sformatf("full.nostall%0d", i), 32'(exers_stall), 32'd0);
    end
    tick();
    chk("full.drop6", 32'(exers_issue_valid), 32'd0);
    tick();
    chk("full.drop6b", 32'(exers_issue_valid), 32'd0);
    // younger ready entry overtakes older waiting one
    put(7'd1, 1'b0, 32'h30, 1'b1, 32'd3);
    tick();
    put(7'd2, 1'b1, 32'd8, 1'b1, 32'd6);
    tick(); idle();
    tick();
    chk_iss("ooo.b", 7'd2, 32'd8, 32'd6);
    wb(7'h30, 32'h55);
    tick(); idle();
    chk("ooo.gap", 32'(exers_issue_valid), 32'd0);
    tick();
    chk_iss("ooo.a", 7'd1, 32'h55, 32'd3);
    tick();
    // flush with 3 entries and a live issue register
    alu_stall = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      put(7'(i), 1'b1, 32'(i), 1'b1, 32'(i));
      tick();
    end
    chk_iss("fl.pre", 7'd10, 32'd10, 32'd10);
    put(7'd14, 1'b1, 32'd14, 1'b1, 32'd14);
    rob_flush = 1'b1;
    tick(); idle();
    chk("fl.valid", 32'(exers_issue_valid), 32'd0);
    chk("fl.stall", 32'(exers_stall), 32'd0);
    for (int i = 20; i <= 24; i++) begin
      put(7'(i), 1'b1, 32'(i), 1'b1, 32'(i));
      tick();
      chk($sformatf("fl.cnt%0d", i), 32'(exers_stall), (i == 24) ? 32'd1 : 32'd0);
    end
    idle();
    chk_iss("fl.first", 7'd20, 32'd20, 32'd20);
    alu_stall = 1'b0;
    tick();
    chk_iss("fl.next", 7'd21, 32'd21, 32'd21);
    // asynchronous reset takes effect without a clock edge
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", 32'(exers_issue_valid), 32'd0);
    chk("arst.stall", 32'(exers_stall), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
